axil_reg_slave: RTL

//  AXI4-Lite responder (slave end of axilite_int) exposing a bank of 32-bit control/status registers.

---
 rtl/axil_reg_slave_if.sv | 40 ++++
 rtl/axil_reg_slave.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register-bank slave.
interface axil_reg_slave_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] AXI_AWADDR;
    logic [2:0]        AXI_AWPROT;
    logic              AXI_AWVALID;
    logic              AXI_AWREADY;
    logic [31:0]       AXI_WDATA;
    logic [3:0]        AXI_WSTRB;
    logic              AXI_WVALID;
    logic              AXI_WREADY;
    logic [1:0]        AXI_BRESP;
    logic              AXI_BVALID;
    logic              AXI_BREADY;
    logic [ADDR_W-1:0] AXI_ARADDR;
    logic [2:0]        AXI_ARPROT;
    logic              AXI_ARVALID;
    logic              AXI_ARREADY;
    logic [31:0]       AXI_RDATA;
    logic [1:0]        AXI_RRESP;
    logic              AXI_RVALID;
    logic              AXI_RREADY;

    modport master (
        output AXI_AWADDR, AXI_AWPROT, AXI_AWVALID, input AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WVALID, input AXI_WREADY,
        input  AXI_BRESP, AXI_BVALID, output AXI_BREADY,
        output AXI_ARADDR, AXI_ARPROT, AXI_ARVALID, input AXI_ARREADY,
        input  AXI_RDATA, AXI_RRESP, AXI_RVALID, output AXI_RREADY
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWPROT, AXI_AWVALID, output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WVALID, output AXI_WREADY,
        output AXI_BRESP, AXI_BVALID, input AXI_BREADY,
        input  AXI_ARADDR, AXI_ARPROT, AXI_ARVALID, output AXI_ARREADY,
        output AXI_RDATA, AXI_RRESP, AXI_RVALID, input AXI_RREADY
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: RW control words out to core logic, RO words mirror status inputs.
// AW and W are buffered independently and committed together; reads are served with one cycle latency.
module axil_reg_slave #(
    parameter int                    C_AXI_DATA_WIDTH = 32,
    parameter int                    C_AXI_ADDR_WIDTH = 9,
    parameter int                    NUM_REGS         = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK          = '0
) (
    input  logic                     AXI_ACLK,
    input  logic                     AXI_ARESETN,
    axil_reg_slave_if.slave          s_axi,
    output logic [NUM_REGS*32-1:0]   reg_out,
    input  logic [NUM_REGS*32-1:0]   reg_in,
    output logic [NUM_REGS-1:0]      wr_pulse
);
    localparam int IW = C_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                          aw_full_q, aw_full_d;
    logic [IW-1:0]                 aw_idx_q, aw_idx_d;
    logic                          w_full_q, w_full_d;
    logic [31:0]                   w_data_q, w_data_d;
    logic [3:0]                    w_strb_q, w_strb_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          rvalid_q, rvalid_d;
    logic [31:0]                   rdata_q, rdata_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic [NUM_REGS-1:0][31:0]     regs_q, regs_d;
    logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;

    logic aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] ar_idx;
    logic unused_ok;

    // Readies are held low for the whole time reset is asserted, not just after the edge.
    assign s_axi.AXI_AWREADY = AXI_ARESETN & ~aw_full_q;
    assign s_axi.AXI_WREADY  = AXI_ARESETN & ~w_full_q;
    assign s_axi.AXI_ARREADY = AXI_ARESETN & ~rvalid_q;
    assign s_axi.AXI_BVALID  = bvalid_q;
    assign s_axi.AXI_BRESP   = bresp_q;
    assign s_axi.AXI_RVALID  = rvalid_q;
    assign s_axi.AXI_RDATA   = rdata_q;
    assign s_axi.AXI_RRESP   = rresp_q;
    assign reg_out           = regs_q;
    assign wr_pulse          = wr_pulse_q;

    assign aw_hs  = s_axi.AXI_AWVALID & s_axi.AXI_AWREADY;
    assign w_hs   = s_axi.AXI_WVALID & s_axi.AXI_WREADY;
    assign ar_hs  = s_axi.AXI_ARVALID & s_axi.AXI_ARREADY;
    assign commit = aw_full_q & w_full_q & ~bvalid_q;
    assign ar_idx = s_axi.AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];

    assign unused_ok = ^{s_axi.AXI_AWPROT, s_axi.AXI_ARPROT,
                         s_axi.AXI_AWADDR[1:0], s_axi.AXI_ARADDR[1:0]};

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.AXI_WDATA;
            w_strb_d = s_axi.AXI_WSTRB;
        end
        if (bvalid_q && s_axi.AXI_BREADY)
            bvalid_d = 1'b0;

        // An index that matches no implemented register falls through to SLVERR.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(aw_idx_q) == i) begin
                    bresp_d       = RESP_OKAY;
                    wr_pulse_d[i] = 1'b1;
                    if (!RO_MASK[i])
                        for (int b = 0; b < 4; b++)
                            if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
        end

        if (rvalid_q && s_axi.AXI_RREADY)
            rvalid_d = 1'b0;
        // Read samples regs_q, so a same-edge commit is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(ar_idx) == i) begin
                    rresp_d = RESP_OKAY;
                    rdata_d = RO_MASK[i] ? reg_in[32*i +: 32] : regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end
endmodule
